ym3438_fsm_param: RTL

YM3438_FSM_PARAM -- requirements
Module: ym3438_fsm_param

---
 rtl/ym3438_pkg.sv | 37 +++
 rtl/ym3438_slot_cnt.sv | 39 +++
 rtl/ym3438_fsm_param.sv | 108 ++++++++++
 3 files changed

// File: rtl/ym3438_pkg.sv
// Shared operator-group encodings and algorithm-decode tables for the slot sequencer.
// Each mask holds bit n set when algorithm n asserts that decode in the indexed group.
package ym3438_pkg;

    typedef enum logic [1:0] {
        OP4 = 2'd0,
        OP1 = 2'd1,
        OP3 = 2'd2,
        OP2 = 2'd3
    } op_grp_e;

    typedef struct packed {
        logic op2;
        logic cur1;
        logic cur2;
        logic op1_0;
        logic out;
    } alg_dec_t;

    // Index [3]=OP2, [2]=OP3, [1]=OP1, [0]=OP4
    localparam logic [3:0][7:0] ALG_OP2_MASK  = {8'h00, 8'h08, 8'h00, 8'h07};
    localparam logic [3:0][7:0] ALG_CUR1_MASK = {8'h00, 8'h1B, 8'h79, 8'h00};
    localparam logic [3:0][7:0] ALG_CUR2_MASK = {8'h00, 8'h04, 8'h00, 8'h00};
    localparam logic [3:0][7:0] ALG_OP10_MASK = {8'hFF, 8'h24, 8'h00, 8'h22};
    localparam logic [3:0][7:0] ALG_OUT_MASK  = {8'hF0, 8'hE0, 8'h80, 8'hFF};

    function automatic alg_dec_t alg_decode(input op_grp_e grp, input logic [2:0] alg);
        alg_dec_t d;
        d.op2   = ALG_OP2_MASK[grp][alg];
        d.cur1  = ALG_CUR1_MASK[grp][alg];
        d.cur2  = ALG_CUR2_MASK[grp][alg];
        d.op1_0 = ALG_OP10_MASK[grp][alg];
        d.out   = ALG_OUT_MASK[grp][alg];
        return d;
    endfunction

endpackage

// File: rtl/ym3438_slot_cnt.sv
// Modulo-MOD counter with sync clear (priority) and increment; carry is combinational.
// No backpressure; holds while neither clear nor increment is asserted.
module ym3438_slot_cnt #(
    parameter int unsigned MOD = 6,
    parameter int unsigned W   = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         carry_o
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign carry_o = inc_i & (cnt_q == LAST);

endmodule

// File: rtl/ym3438_fsm_param.sv
// Operator slot sequencer over 4*NUM_CH slots; registered decodes lag one enabled slot.
// No backpressure; clk_en low freezes every register and therefore every output.
module ym3438_fsm_param
    import ym3438_pkg::*;
#(
    parameter int unsigned NUM_CH     = 6,
    parameter int unsigned CH3_IDX    = 2,
    parameter int unsigned TIMER_SLOT = 2
) (
    input  logic                        MCLK,
    input  logic                        IC,
    input  logic                        clk_en,
    input  logic                        fsm_reset,
    input  logic [2:0]                  connect,
    output logic [$clog2(4*NUM_CH)-1:0] slot,
    output logic [2:0]                  ch_idx,
    output logic [1:0]                  op_grp,
    output logic                        op4_sel,
    output logic                        op1_sel,
    output logic                        op3_sel,
    output logic                        op2_sel,
    output logic                        ch3_sel,
    output logic                        frame_start,
    output logic                        timer_ed,
    output logic                        alg_fb_sel,
    output logic                        alg_op2,
    output logic                        alg_cur1,
    output logic                        alg_cur2,
    output logic                        alg_op1_0,
    output logic                        alg_out
);

    localparam int unsigned SLOTS = 4 * NUM_CH;
    localparam int unsigned SW    = $clog2(SLOTS);
    localparam logic [SW-1:0] TIMER_PREV = SW'((TIMER_SLOT + SLOTS - 1) % SLOTS);

    logic     clr, ch_carry, grp_carry;
    logic     timer_q, timer_d;
    logic     fb_q, fb_d;
    alg_dec_t alg_q, alg_d;

    assign clr = clk_en & fsm_reset;

    ym3438_slot_cnt #(.MOD(NUM_CH), .W(3)) u_ch_cnt (
        .clk_i   (MCLK),
        .rst_ni  (IC),
        .clr_i   (clr),
        .inc_i   (clk_en),
        .cnt_o   (ch_idx),
        .carry_o (ch_carry)
    );

    ym3438_slot_cnt #(.MOD(4), .W(2)) u_grp_cnt (
        .clk_i   (MCLK),
        .rst_ni  (IC),
        .clr_i   (clr),
        .inc_i   (ch_carry),
        .cnt_o   (op_grp),
        .carry_o (grp_carry)
    );

    assign slot        = SW'(op_grp) * SW'(NUM_CH) + SW'(ch_idx);
    assign op4_sel     = (op_grp == OP4);
    assign op1_sel     = (op_grp == OP1);
    assign op3_sel     = (op_grp == OP3);
    assign op2_sel     = (op_grp == OP2);
    assign ch3_sel     = (ch_idx == 3'(CH3_IDX));
    assign frame_start = (slot == '0);

    // Entering slot 0 by natural wrap is exactly the group-counter carry.
    always_comb begin
        timer_d = 1'b0;
        fb_d    = fb_q;
        alg_d   = alg_q;
        if (clk_en) begin
            fb_d  = ~op3_sel;
            alg_d = alg_decode(op_grp_e'(op_grp), connect);
            if (fsm_reset) begin
                timer_d = (TIMER_SLOT == 0);
            end else if (TIMER_SLOT == 0) begin
                timer_d = grp_carry;
            end else begin
                timer_d = (slot == TIMER_PREV);
            end
        end
    end

    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            timer_q <= 1'b0;
            fb_q    <= 1'b1;
            alg_q   <= '0;
        end else begin
            timer_q <= timer_d;
            fb_q    <= fb_d;
            alg_q   <= alg_d;
        end
    end

    assign timer_ed   = timer_q;
    assign alg_fb_sel = fb_q;
    assign alg_op2    = alg_q.op2;
    assign alg_cur1   = alg_q.cur1;
    assign alg_cur2   = alg_q.cur2;
    assign alg_op1_0  = alg_q.op1_0;
    assign alg_out    = alg_q.out;

endmodule
